// File: rtl/ivi_pkg.sv
// Shared definitions for the interval-result UART reporter.
// Holds digit/frame sizes, ASCII constants, the serializer state enum,
// and the byte-selection helpers used by the top level.
package ivi_pkg;

  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 9;
  localparam int FRAME_LEN  = 13;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // Element 0 is mil_100 (first digit on the wire).
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  function automatic logic [7:0] ascii_digit(logic [DIGIT_W-1:0] x);
    return (x <= 5'd9) ? (ASCII_ZERO + {3'b000, x}) : ASCII_QMARK;
  endfunction

  function automatic logic [7:0] frame_byte(digits_t d, logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = ascii_digit(d[0]);
      4'd1:    b = ascii_digit(d[1]);
      4'd2:    b = ascii_digit(d[2]);
      4'd3:    b = ASCII_DOT;
      4'd4:    b = ascii_digit(d[3]);
      4'd5:    b = ascii_digit(d[4]);
      4'd6:    b = ascii_digit(d[5]);
      4'd7:    b = ASCII_DOT;
      4'd8:    b = ascii_digit(d[6]);
      4'd9:    b = ascii_digit(d[7]);
      4'd10:   b = ascii_digit(d[8]);
      4'd11:   b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ivi_result_uart_if.sv
// Result bus from the interval measurer: the result-valid level plus the
// nine BCD digits, most significant first.
//   master : the measurer (drives everything)
//   slave  : the UART reporter (samples everything)
interface ivi_result_uart_if;
  import ivi_pkg::*;

  logic               end_measurement;
  logic [DIGIT_W-1:0] mil_100, mil_010, mil_001;
  logic [DIGIT_W-1:0] mic_100, mic_010, mic_001;
  logic [DIGIT_W-1:0] n_100, n_010, n_001;

  modport master (output end_measurement,
                  output mil_100, mil_010, mil_001,
                  output mic_100, mic_010, mic_001,
                  output n_100, n_010, n_001);

  modport slave  (input end_measurement,
                  input mil_100, mil_010, mil_001,
                  input mic_100, mic_010, mic_001,
                  input n_100, n_010, n_001);
endinterface

// File: rtl/ivi_uart_tx_byte.sv
// 8N1 byte serializer, LSB first, idle high.
// Ports:
//   clk_200MHz, reset (sync, active low)
//   load  : accepted in IDLE, or in the last stop-bit cycle so bytes chain
//           with no idle gap
//   data  : byte to send, sampled with load
//   done  : high during the last cycle of the stop bit
//   tx    : registered UART line
module ivi_uart_tx_byte
  import ivi_pkg::*;
#(
  parameter int CLK_DIV = 1736
) (
  input  logic       clk_200MHz,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  uart_state_e state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        tx_q;

  wire bit_end = (cnt_q == BIT_LAST);

  assign done = (state_q == ST_STOP) && bit_end;
  assign tx   = tx_q;

  always_ff @(posedge clk_200MHz) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (load) begin
            state_q <= ST_START;
            sh_q    <= data;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              // Shift so the next data bit is always in sh_q[1].
              bit_q <= bit_q + 3'd1;
              sh_q  <= {1'b0, sh_q[7:1]};
              tx_q  <= sh_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin // ST_STOP
          if (bit_end) begin
            cnt_q <= '0;
            if (load) begin
              state_q <= ST_START;
              sh_q    <= data;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ivi_result_uart.sv
// Sends each new interval result as a 13-byte ASCII line
// "DDD.DDD.DDD\r\n" over an 8N1 UART.
// Ports:
//   clk_200MHz, reset (sync, active low)
//   res        : result bus (slave side) -- end_measurement + 9 BCD digits
//   tx_enable  : 0 drops new results; an in-flight frame still completes
//   tx         : UART line
//   busy       : frame in progress (start of byte 0 .. end of byte 12 stop)
//   frame_done : one-cycle pulse after the final stop bit
//   overrun    : sticky, a result edge arrived while busy
module ivi_result_uart
  import ivi_pkg::*;
#(
  parameter int CLK_DIV = 1736
) (
  input  logic                clk_200MHz,
  input  logic                reset,
  ivi_result_uart_if.slave    res,
  input  logic                tx_enable,
  output logic                tx,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam logic [3:0] IDX_LAST = 4'(FRAME_LEN - 1);

  digits_t    live;
  digits_t    dig_q, dig_d;
  logic [3:0] idx_q, idx_d;
  logic       em_q, em_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       overrun_q, overrun_d;
  logic       ld;
  logic [7:0] ld_data;
  logic       byte_done;
  logic       trig, accept;

  always_comb begin
    live[0] = res.mil_100;
    live[1] = res.mil_010;
    live[2] = res.mil_001;
    live[3] = res.mic_100;
    live[4] = res.mic_010;
    live[5] = res.mic_001;
    live[6] = res.n_100;
    live[7] = res.n_010;
    live[8] = res.n_001;
  end

  assign trig   = res.end_measurement & ~em_q;
  assign accept = trig & ~busy_q & tx_enable;

  always_comb begin
    em_d         = res.end_measurement;
    dig_d        = dig_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (trig & busy_q);
    ld           = 1'b0;
    ld_data      = frame_byte(dig_q, idx_q + 4'd1);
    if (accept) begin
      // Byte 0 comes straight from the live digits: the capture lands in
      // the same cycle the serializer loads.
      dig_d   = live;
      idx_d   = '0;
      busy_d  = 1'b1;
      ld      = 1'b1;
      ld_data = frame_byte(live, 4'd0);
    end else if (byte_done) begin
      if (idx_q < IDX_LAST) begin
        idx_d = idx_q + 4'd1;
        ld    = 1'b1;
      end else begin
        idx_d        = '0;
        busy_d       = 1'b0;
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_200MHz) begin
    if (!reset) begin
      em_q         <= 1'b1;  // post-reset high level is not a new result
      dig_q        <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      em_q         <= em_d;
      dig_q        <= dig_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  ivi_uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk_200MHz (clk_200MHz),
    .reset      (reset),
    .load       (ld),
    .data       (ld_data),
    .done       (byte_done),
    .tx         (tx)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
